// File: rtl/adder_accumulator.sv
// Frame accumulator: sums DEPTH operands with carry-in on the first beat,
// and holds the result and a sticky carry-out until downstream accepts it.
module adder_accumulator #(
    parameter int N     = 4,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clear,
    input  logic         cin,
    input  logic [N-1:0] a,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [N-1:0] sum,
    output logic         cout,
    output logic         out_valid,
    input  logic         out_ready
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [N-1:0]  acc_q, acc_d;
    logic          cout_q, cout_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic          beat;
    logic [N-1:0]  add_base;
    logic          add_cin;
    logic [N:0]    add_res;
    logic [CW-1:0] cnt_inc;

    assign in_ready  = (state_q != DONE);
    assign out_valid = (state_q == DONE);
    assign sum       = acc_q;
    assign cout      = cout_q;
    assign beat      = in_valid & in_ready;
    assign cnt_inc   = cnt_q + CW'(1);

    // The first beat of a frame starts from zero and takes the carry-in.
    assign add_base = (state_q == IDLE) ? '0 : acc_q;
    assign add_cin  = (state_q == IDLE) ? cin : 1'b0;
    assign add_res  = {1'b0, add_base} + {1'b0, a} + {{N{1'b0}}, add_cin};

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cout_d  = cout_q;
        cnt_d   = cnt_q;
        if (clear) begin
            state_d = IDLE;
            acc_d   = '0;
            cout_d  = 1'b0;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (beat) begin
                        acc_d   = add_res[N-1:0];
                        cout_d  = add_res[N];
                        cnt_d   = CW'(1);
                        state_d = (DEPTH == 1) ? DONE : ACC;
                    end
                end
                ACC: begin
                    if (beat) begin
                        acc_d  = add_res[N-1:0];
                        cout_d = cout_q | add_res[N];
                        cnt_d  = cnt_inc;
                        if (cnt_inc == DEPTH_C) begin
                            state_d = DONE;
                        end
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_d = IDLE;
                        acc_d   = '0;
                        cout_d  = 1'b0;
                        cnt_d   = '0;
                    end
                end
                default: begin
                    state_d = IDLE;
                    acc_d   = '0;
                    cout_d  = 1'b0;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            acc_q   <= '0;
            cout_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cout_q  <= cout_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_adder_accumulator.sv
// Scoreboard bench for adder_accumulator (N=4, DEPTH=4): directed frames,
// expected {sum,cout} queued at issue and checked on each output handshake.
module tb_adder_accumulator;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       clear = 1'b0;
    logic       cin = 1'b0;
    logic [3:0] a = 4'd0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [3:0] sum;
    logic       cout;
    logic       out_valid;
    logic       out_ready = 1'b0;

    int total = 0;
    int bad   = 0;

    logic [4:0] exp_q[$];

    adder_accumulator #(.N(4), .DEPTH(4)) dut (
        .clk(clk),
        .rst(rst),
        .clear(clear),
        .cin(cin),
        .a(a),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .sum(sum),
        .cout(cout),
        .out_valid(out_valid),
        .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: every accepted result must match the oldest expectation.
    always @(negedge clk) begin
        if (!rst && !clear && out_valid && out_ready) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL result: got %0h/%0b with no expectation",
                         sum, cout);
            end else begin
                logic [4:0] e;
                e = exp_q.pop_front();
                if ({sum, cout} != e) begin
                    bad++;
                    $display("FAIL result: got sum=%0h cout=%0b expected sum=%0h cout=%0b",
                             sum, cout, e[4:1], e[0]);
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic [3:0] v, input logic c);
        a = v;
        cin = c;
        in_valid = 1'b1;
        tick(1);
        in_valid = 1'b0;
        cin = 1'b0;
    endtask

    task automatic frame(input logic [3:0] v0, input logic [3:0] v1,
                         input logic [3:0] v2, input logic [3:0] v3,
                         input logic c);
        beat(v0, c);
        beat(v1, c);
        beat(v2, c);
        check("no_early_valid", int'(out_valid), 0);
        beat(v3, c);
        check("valid_1cyc", int'(out_valid), 1);
    endtask

    task automatic consume();
        int waited = 0;
        out_ready = 1'b1;
        while (!out_valid && waited < 20) begin
            tick(1);
            waited++;
        end
        if (!out_valid) check("consume_timeout", 0, 1);
        tick(1);
        out_ready = 1'b0;
        check("idle_in_ready", int'(in_ready), 1);
        check("idle_out_valid", int'(out_valid), 0);
        check("idle_sum", int'(sum), 0);
        check("idle_cout", int'(cout), 0);
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_sum"}, int'(sum), 0);
        check({tag, "_cout"}, int'(cout), 0);
        check({tag, "_out_valid"}, int'(out_valid), 0);
        check({tag, "_in_ready"}, int'(in_ready), 1);
    endtask

    initial begin
        tick(2);
        rst = 1'b0;
        check_reset("reset");

        // Overflow chain: F+C=B c, B+B=6 c, 6+D=3 c
        exp_q.push_back({4'b0011, 1'b1});
        frame(4'hF, 4'hC, 4'hB, 4'hD, 1'b0);
        check("f1_sum", int'(sum), 3);
        check("f1_cout", int'(cout), 1);
        consume();

        // Carry-in only counts on the first beat
        exp_q.push_back({4'b0001, 1'b0});
        frame(4'h0, 4'h0, 4'h0, 4'h0, 1'b1);
        consume();

        // Back-pressure in DONE with in_valid high
        exp_q.push_back({4'hC, 1'b0});
        frame(4'h3, 4'h3, 4'h3, 4'h3, 1'b0);
        a = 4'h5;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick(1);
            check("stall_in_ready", int'(in_ready), 0);
            check("stall_sum", int'(sum), 12);
            check("stall_cout", int'(cout), 0);
            check("stall_valid", int'(out_valid), 1);
        end
        in_valid = 1'b0;
        consume();

        // Gaps between beats
        exp_q.push_back({4'b0100, 1'b0});
        beat(4'h1, 1'b0);
        tick(2);
        beat(4'h1, 1'b0);
        tick(1);
        beat(4'h1, 1'b0);
        tick(3);
        check("gap_sum3", int'(sum), 3);
        check("gap_no_valid", int'(out_valid), 0);
        beat(4'h1, 1'b0);
        check("gap_valid", int'(out_valid), 1);
        consume();

        // Clear coincident with a third beat
        beat(4'h2, 1'b0);
        beat(4'h2, 1'b0);
        a = 4'h2;
        in_valid = 1'b1;
        clear = 1'b1;
        tick(1);
        clear = 1'b0;
        in_valid = 1'b0;
        check_reset("clear");
        exp_q.push_back({4'b1000, 1'b0});
        frame(4'h2, 4'h2, 4'h2, 4'h2, 1'b0);
        consume();

        // Reset in DONE: 7+7+7+7 = 28 -> C, never consumed
        frame(4'h7, 4'h7, 4'h7, 4'h7, 1'b0);
        check("rd_sum", int'(sum), 12);
        check("rd_cout", int'(cout), 1);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        check_reset("rst_done");

        // Reset mid-frame
        beat(4'h9, 1'b0);
        beat(4'h9, 1'b0);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        check_reset("rst_mid");
        exp_q.push_back({4'hA, 1'b0});
        frame(4'h1, 4'h2, 4'h3, 4'h4, 1'b0);
        consume();

        // Wrap with carry-in: 8+1=9, +8=1 c, +8=9, +8=1 c
        exp_q.push_back({4'h1, 1'b1});
        beat(4'h8, 1'b1);
        beat(4'h8, 1'b0);
        beat(4'h8, 1'b0);
        beat(4'h8, 1'b0);
        check("wrap_valid", int'(out_valid), 1);
        consume();

        tick(2);
        check("queue_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
